uart_tx_cfg: RTL and testbench

//  Next-generation UART transmitter: runtime-selectable frame (5-9 data bits, none/even/odd parity, 1 or 2 stop bits).

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_tx_bit_timer.sv | 47 ++++
 rtl/uart_tx_cfg.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int DBITS_MIN = 5;

    function automatic logic [3:0] clamp_dbits(input logic [3:0] cfg, input int max_bits);
        if (int'(cfg) < DBITS_MIN) begin
            return 4'(DBITS_MIN);
        end else if (int'(cfg) > max_bits) begin
            return 4'(max_bits);
        end else begin
            return cfg;
        end
    endfunction

    // Only the low 'width' bits take part; unknown mode (11) behaves as none.
    function automatic logic parity_bit(input logic [15:0] data, input logic [3:0] width,
                                        input logic [1:0] mode);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(width)) begin
                acc = acc ^ data[i];
            end
        end
        case (mode)
            PAR_EVEN: return acc;
            PAR_ODD:  return ~acc;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts sample_ticks while a frame is active and strobes at
// the end of each bit (bit_end) and at the end of the current span (stop_end).
module uart_tx_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic run,
    input  logic clr,
    input  logic span2,
    input  logic sample_tick,
    output logic bit_end,
    output logic stop_end
);

    localparam int CNT_W = $clog2(2 * OVERSAMPLE);
    localparam int LOW_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] ONE_BIT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] TWO_BIT = CNT_W'(2 * OVERSAMPLE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_en;
    logic [CNT_W-1:0] last_cnt;

    assign tick_en  = run & sample_tick;
    assign last_cnt = span2 ? TWO_BIT : ONE_BIT;
    assign bit_end  = tick_en & (cnt_q[LOW_W-1:0] == LOW_W'(OVERSAMPLE - 1));
    assign stop_end = tick_en & (cnt_q == last_cnt);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || clr || stop_end) begin
            cnt_d = '0;
        end else if (tick_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5-9 data bits, none/even/odd parity, 1-2 stop bits).
// Optional line-break generation is built when UART_TX_BREAK_EN is defined.
//
// state  | meaning
// IDLE   | line high, ready for a word (or break request)
// START  | start bit, line low
// DATA   | data bits LSB first, one per bit period
// PARITY | parity bit (skipped when parity is none)
// STOP   | one or two stop bit-times high; tx_done at the end of a frame
// BREAK  | line held low for the break length and while brk_req stays high
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DBITS_MAX  = 9,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DBITS_MAX-1:0] data_in,
    input  logic [3:0]           cfg_dbits,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk_req,
`endif
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

`ifdef UART_TX_BREAK_EN
    localparam logic [3:0] BRK_BITS = 4'(DBITS_MAX + 4);
`endif

    state_t               state_q, state_d;
    logic [DBITS_MAX-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [3:0]           dbits_q, dbits_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 brk_q, brk_d;
    logic                 tx_q, tx_d;
    logic                 tx_done_q, tx_done_d;

    logic                 bit_end, stop_end, timer_clr;
    logic [3:0]           dbits_in;

    assign dbits_in = clamp_dbits(cfg_dbits, DBITS_MAX);

`ifdef UART_TX_BREAK_EN
    assign tx_ready = (state_q == IDLE) & ~reset & ~brk_req;
`else
    assign tx_ready = (state_q == IDLE) & ~reset;
`endif
    assign tx_busy = (state_q != IDLE);
    assign tx_done = tx_done_q;
    assign tx      = tx_q;

    uart_tx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .run         (state_q != IDLE),
        .clr         (timer_clr),
        .span2       ((state_q == STOP) & stop2_q),
        .sample_tick (sample_tick),
        .bit_end     (bit_end),
        .stop_end    (stop_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        dbits_d   = dbits_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        brk_d     = brk_q;
        tx_done_d = 1'b0;
        timer_clr = 1'b0;
        tx_d      = 1'b1;

        case (state_q)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (brk_req) begin
                    state_d   = BREAK;
                    brk_d     = 1'b1;
                    stop2_d   = 1'b1;
                    bit_cnt_d = '0;
                end else
`endif
                if (tx_valid) begin
                    state_d   = START;
                    shift_d   = data_in;
                    dbits_d   = dbits_in;
                    par_en_d  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
                    par_bit_d = parity_bit(16'(data_in), dbits_in, cfg_parity);
                    stop2_d   = cfg_stop2;
                    brk_d     = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == dbits_q - 4'd1) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                tx_d = par_bit_q;
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (stop_end) begin
                    state_d   = IDLE;
                    tx_done_d = ~brk_q;
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                tx_d = 1'b0;
                // Once the minimum length is reached the timer is parked at zero so
                // the stop period starts on a clean bit boundary.
                if (bit_cnt_q == BRK_BITS) begin
                    timer_clr = 1'b1;
                    if (!brk_req) begin
                        state_d = STOP;
                    end
                end else if (bit_end) begin
                    if (bit_cnt_q == BRK_BITS - 4'd1) begin
                        if (!brk_req) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = BRK_BITS;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            dbits_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            brk_q     <= 1'b0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            dbits_q   <= dbits_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            brk_q     <= brk_d;
            tx_q      <= tx_d;
            tx_done_q <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: table-driven frames, hand sequences for reset/back-to-back,
// and randomized frames checked against a bit-list model of the serial line.
module tb_uart_tx_cfg;

    localparam int OS = 16;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       tx_valid;
    logic       tx_ready;
    logic [8:0] data_in;
    logic [3:0] cfg_dbits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
`ifdef UART_TX_BREAK_EN
    logic       brk_req;
`endif
    logic       tx_busy;
    logic       tx_done;
    logic       tx;

    int n_cmp = 0;
    int n_err = 0;
    int tick_div = 1;
    int tick_phase = 0;

    uart_tx_cfg #(.DBITS_MAX(9), .OVERSAMPLE(OS)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .sample_tick (sample_tick),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .data_in     (data_in),
        .cfg_dbits   (cfg_dbits),
        .cfg_parity  (cfg_parity),
        .cfg_stop2   (cfg_stop2),
`ifdef UART_TX_BREAK_EN
        .brk_req     (brk_req),
`endif
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx          (tx)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(negedge clk_100MHz) begin
        sample_tick = (tick_phase == 0);
        tick_phase  = (tick_phase + 1 >= tick_div) ? 0 : tick_phase + 1;
    end

    typedef struct {
        logic [8:0] data;
        logic [3:0] dbits;
        logic [1:0] par;
        logic       stop2;
        int         div;
        logic       keep;
        int         exp_ticks;
        logic       chk_par;
        logic       exp_par;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        data_in    = v.data;
        cfg_dbits  = v.dbits;
        cfg_parity = v.par;
        cfg_stop2  = v.stop2;
        tx_valid   = 1'b1;
    endtask

    // Sends one frame and checks the line every cycle against the expected bit list.
    // Caller is positioned #1 after a rising edge.
    task automatic play(input vec_t v, input vec_t nxt, input logic predriven);
        logic bq[$];
        int   d, ones, total, t, prev_t, bound;
        logic pen, pb, par_seen, tk, got_done, ready_ok;

        d = (v.dbits < 5) ? 5 : ((v.dbits > 9) ? 9 : int'(v.dbits));
        ones = 0;
        for (int i = 0; i < d; i++) ones += int'(v.data[i]);
        pen = (v.par == 2'b01) || (v.par == 2'b10);
        pb  = (v.par == 2'b01) ? logic'(ones % 2) : logic'(1 - ones % 2);
        bq.push_back(1'b0);
        for (int i = 0; i < d; i++) bq.push_back(v.data[i]);
        if (pen) bq.push_back(pb);
        bq.push_back(1'b1);
        if (v.stop2) bq.push_back(1'b1);
        total = OS * bq.size();

        tick_div = v.div;
        if (predriven) chk("ready_back_to_back", tx_ready, 1);
        else drive(v);

        ready_ok = 1'b0;
        for (int w = 0; w < 8; w++) begin
            if (tx_ready) begin
                ready_ok = 1'b1;
                break;
            end
            @(posedge clk_100MHz); #1;
        end
        if (!ready_ok) chk("accept_timeout", 0, 1);

        @(posedge clk_100MHz); #1;
        chk("line_high_at_accept", tx, 1);
        chk("busy_after_accept", tx_busy, 1);
        if (v.keep) begin
            drive(nxt);
        end else begin
            tx_valid   = 1'b0;
            data_in    = 9'($urandom);
            cfg_dbits  = 4'($urandom);
            cfg_parity = 2'($urandom);
            cfg_stop2  = 1'($urandom);
        end

        t = 0;
        got_done = 1'b0;
        par_seen = 1'bx;
        bound = total * v.div + 4 * OS;
        for (int m = 1; m <= bound; m++) begin
            @(posedge clk_100MHz);
            tk = sample_tick;
            #1;
            prev_t = t;
            if (tk) t++;
            if (prev_t < total) chk("tx_bit", tx, bq[prev_t / OS]);
            chk("tx_done_timing", tx_done, t == total);
            chk("tx_busy", tx_busy, t != total);
            chk("tx_ready_in_frame", tx_ready, t == total);
            if (pen && (prev_t / OS == 1 + d)) par_seen = tx;
            if (tx_done) begin
                got_done = 1'b1;
                break;
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        if (v.exp_ticks != 0) chk("frame_ticks", t, v.exp_ticks);
        if (v.chk_par) chk("parity_bit", par_seen, v.exp_par);
        chk("line_high_after_frame", tx, 1);
    endtask

    vec_t tab[9];
    vec_t rnd[12];

    initial begin
        //          data    dbits par    s2    div keep ticks chkp expp
        tab[0] = '{9'h055, 4'd8,  2'b00, 1'b0, 1, 1'b0, 160, 1'b0, 1'b0};
        tab[1] = '{9'h041, 4'd7,  2'b01, 1'b1, 1, 1'b0, 176, 1'b1, 1'b0};
        tab[2] = '{9'h1FF, 4'd9,  2'b10, 1'b0, 1, 1'b0, 192, 1'b1, 1'b0};
        tab[3] = '{9'h1FF, 4'd12, 2'b10, 1'b0, 1, 1'b0, 192, 1'b1, 1'b0};
        tab[4] = '{9'h0AB, 4'd2,  2'b01, 1'b0, 1, 1'b0, 128, 1'b1, 1'b1};
        tab[5] = '{9'h0F0, 4'd6,  2'b11, 1'b1, 1, 1'b0, 144, 1'b0, 1'b0};
        tab[6] = '{9'h0A5, 4'd8,  2'b00, 1'b0, 1, 1'b1, 160, 1'b0, 1'b0};
        tab[7] = '{9'h03C, 4'd8,  2'b00, 1'b0, 1, 1'b0, 160, 1'b0, 1'b0};
        tab[8] = '{9'h055, 4'd8,  2'b00, 1'b0, 4, 1'b0, 160, 1'b0, 1'b0};

        reset = 1'b1;
        tx_valid = 1'b0;
        data_in = '0;
        cfg_dbits = 4'd8;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_req = 1'b0;
`endif
        repeat (3) @(posedge clk_100MHz);
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_done", tx_done, 0);
        chk("reset_ready", tx_ready, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", tx_ready, 1);
        @(posedge clk_100MHz); #1;

        for (int i = 0; i < 9; i++) begin
            play(tab[i], (i + 1 < 9) ? tab[i + 1] : tab[i], (i > 0) ? tab[i - 1].keep : 1'b0);
        end

        // Reset 70 ticks into an 8N1 frame, then a clean frame afterwards.
        tick_div = 1;
        drive(tab[0]);
        @(posedge clk_100MHz); #1;
        tx_valid = 1'b0;
        repeat (70) @(posedge clk_100MHz);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_100MHz); #1;
            chk("midreset_tx", tx, 1);
            chk("midreset_busy", tx_busy, 0);
            chk("midreset_done", tx_done, 0);
            chk("midreset_ready", tx_ready, 0);
        end
        reset = 1'b0;
        #1;
        play(tab[1], tab[1], 1'b0);

        for (int i = 0; i < 12; i++) begin
            rnd[i].data      = 9'($urandom_range(0, 511));
            rnd[i].dbits     = 4'($urandom_range(0, 15));
            rnd[i].par       = 2'($urandom_range(0, 3));
            rnd[i].stop2     = 1'($urandom_range(0, 1));
            rnd[i].div       = $urandom_range(1, 3);
            rnd[i].keep      = (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
            rnd[i].exp_ticks = 0;
            rnd[i].chk_par   = 1'b0;
            rnd[i].exp_par   = 1'b0;
        end
        for (int i = 0; i < 12; i++) begin
            play(rnd[i], (i + 1 < 12) ? rnd[i + 1] : rnd[i], (i > 0) ? rnd[i - 1].keep : 1'b0);
        end

`ifdef UART_TX_BREAK_EN
        begin
            int low_cnt, rise_at, fall_at;
            logic seen_done;
            tick_div = 1;
            tx_valid = 1'b0;
            brk_req = 1'b1;
            @(posedge clk_100MHz); #1;
            brk_req = 1'b0;
            low_cnt = 0;
            rise_at = -1;
            fall_at = -1;
            seen_done = 1'b0;
            for (int m = 1; m <= 400; m++) begin
                @(posedge clk_100MHz); #1;
                if (tx == 1'b0) low_cnt++;
                if (tx == 1'b1 && rise_at < 0) rise_at = m;
                if (tx_done) seen_done = 1'b1;
                if (tx_busy == 1'b0) begin
                    fall_at = m;
                    break;
                end
                chk("break_ready_low", tx_ready, 0);
            end
            chk("break_low_ticks", low_cnt, 13 * OS);
            chk("break_stop_ticks", fall_at - rise_at + 1, 2 * OS);
            chk("break_no_done", seen_done, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
